net_iso_multi_reg_file: RTL and testbench

NET_ISO_MULTI_REG_FILE -- requirements
Module: net_iso_multi_reg_file

---
 rtl/net_iso_pkg.sv | 42 ++++
 rtl/net_iso_stat_counter.sv | 18 +
 rtl/net_iso_multi_reg_file.sv | 226 ++++++++++++++++++++++
 tb/tb_net_iso_multi_reg_file.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/net_iso_pkg.sv
// Shared register map, response codes and FSM state types for the network isolation register file.
// Optional interrupt-mask register at +0x14 is enabled by NET_ISO_IRQ_EN.
package net_iso_pkg;

  localparam logic [4:0] OFF_CTRL = 5'h00;
  localparam logic [4:0] OFF_ERR  = 5'h04;
  localparam logic [4:0] OFF_INIT = 5'h08;
  localparam logic [4:0] OFF_UPD  = 5'h0C;
  localparam logic [4:0] OFF_STAT = 5'h10;
  localparam logic [4:0] OFF_MASK = 5'h14;

  localparam int CH_STRIDE = 32'h20;
  localparam int CH_SHIFT  = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  function automatic logic off_mapped(input logic [4:0] off);
    logic hit;
    case (off)
      OFF_CTRL, OFF_ERR, OFF_INIT, OFF_UPD, OFF_STAT: hit = 1'b1;
`ifdef NET_ISO_IRQ_EN
      OFF_MASK: hit = 1'b1;
`endif
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/net_iso_stat_counter.sv
// Saturating per-channel drop counter; a clear wins over a coincident increment.
module net_iso_stat_counter #(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [STAT_WIDTH-1:0] cnt
);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/net_iso_multi_reg_file.sv
// AXI-Lite register file for NUM_CH isolated network channels (0x20 stride per channel).
// Define NET_ISO_IRQ_EN to add the per-channel irq mask at +0x14 and the registered irq output.
module net_iso_multi_reg_file
  import net_iso_pkg::*;
#(
  parameter int NUM_CH                 = 4,
  parameter int TOKEN_COUNT_INT_WIDTH  = 16,
  parameter int TOKEN_COUNT_FRAC_WIDTH = 8,
  parameter int STAT_WIDTH             = 32
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic [31:0]                                awaddr,
  input  logic                                       awvalid,
  output logic                                       awready,
  input  logic [31:0]                                wdata,
  input  logic [3:0]                                 wstrb,
  input  logic                                       wvalid,
  output logic                                       wready,
  output logic [1:0]                                 bresp,
  output logic                                       bvalid,
  input  logic                                       bready,
  input  logic [31:0]                                araddr,
  input  logic                                       arvalid,
  output logic                                       arready,
  output logic [31:0]                                rdata,
  output logic [1:0]                                 rresp,
  output logic                                       rvalid,
  input  logic                                       rready,
  output logic [NUM_CH-1:0]                          decouple,
  input  logic [NUM_CH-1:0]                          decouple_done,
  input  logic [2*NUM_CH-1:0]                        decouple_status_vector,
  input  logic [NUM_CH-1:0]                          oversize_error_irq,
  output logic [NUM_CH-1:0]                          oversize_error_clear,
  input  logic [NUM_CH-1:0]                          timeout_error_irq,
  output logic [NUM_CH-1:0]                          timeout_error_clear,
  input  logic [NUM_CH-1:0]                          rx_packet_dropped,
  output logic [NUM_CH*TOKEN_COUNT_INT_WIDTH-1:0]    init_token,
  output logic [NUM_CH*(TOKEN_COUNT_FRAC_WIDTH+1)-1:0] upd_token,
  output logic                                       irq
);

  localparam int IW = TOKEN_COUNT_INT_WIDTH;
  localparam int UW = TOKEN_COUNT_FRAC_WIDTH + 1;
  localparam logic [7:0] NCH = 8'(NUM_CH);

  wr_state_e wr_st, wr_nx;
  rd_state_e rd_st, rd_nx;

  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_word;
  logic [7:0]  wr_ch, rd_ch;
  logic [4:0]  wr_off, rd_off;
  logic        wr_hit, rd_hit, wr_fire;

  logic [NUM_CH-1:0]                 dec_q, ovc_q, toc_q;
  logic [NUM_CH-1:0][IW-1:0]         init_q;
  logic [NUM_CH-1:0][UW-1:0]         upd_q;
  logic [NUM_CH-1:0][STAT_WIDTH-1:0] cnt_q;

  logic unused_addr;
  assign unused_addr = ^{awaddr[31:12], araddr[31:12]};

  // ---------------- FSMs ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_st <= W_IDLE;
      rd_st <= R_IDLE;
    end else begin
      wr_st <= wr_nx;
      rd_st <= rd_nx;
    end
  end

  always_comb begin
    wr_nx = wr_st;
    case (wr_st)
      W_IDLE:  if (awvalid && wvalid) wr_nx = W_ACK;
      W_ACK:   wr_nx = W_RESP;
      W_RESP:  if (bready) wr_nx = W_IDLE;
      default: wr_nx = W_IDLE;
    endcase
  end

  always_comb begin
    rd_nx = rd_st;
    case (rd_st)
      R_IDLE:  if (arvalid) rd_nx = R_ACK;
      R_ACK:   rd_nx = R_DATA;
      R_DATA:  if (rready) rd_nx = R_IDLE;
      default: rd_nx = R_IDLE;
    endcase
  end

  assign awready = (wr_st == W_ACK);
  assign wready  = (wr_st == W_ACK);
  assign bvalid  = (wr_st == W_RESP);
  assign arready = (rd_st == R_ACK);
  assign rvalid  = (rd_st == R_DATA);
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  // ---------------- decode ----------------
  assign wr_ch   = {1'b0, awaddr[11:5]};
  assign wr_off  = awaddr[4:0];
  assign rd_ch   = {1'b0, araddr[11:5]};
  assign rd_off  = araddr[4:0];
  assign wr_hit  = off_mapped(wr_off) && (wr_ch < NCH);
  assign rd_hit  = off_mapped(rd_off) && (rd_ch < NCH);
  assign wr_fire = (wr_st == W_ACK) && wr_hit;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)               bresp_q <= RESP_OKAY;
    else if (wr_st == W_ACK)  bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
  end

  // ---------------- per-channel registers ----------------
`ifdef NET_ISO_IRQ_EN
  logic [NUM_CH-1:0][1:0] mask_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [7:0] CI = 8'(c);
    logic          sel;
    logic          dec_r, ovc_r, toc_r;
    logic [IW-1:0] init_r;
    logic [UW-1:0] upd_r;

    assign sel = wr_fire && (wr_ch == CI);

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        dec_r  <= 1'b0;
        ovc_r  <= 1'b0;
        toc_r  <= 1'b0;
        init_r <= '0;
        upd_r  <= '0;
      end else begin
        // Pulse lives only in the cycle after the accepting write.
        toc_r <= sel && (wr_off == OFF_ERR) && wstrb[0] && wdata[1];
        if (sel && (wr_off == OFF_CTRL) && wstrb[0]) dec_r <= wdata[0];
        if (sel && (wr_off == OFF_ERR)  && wstrb[0]) ovc_r <= wdata[0];
        if (sel && (wr_off == OFF_INIT)) init_r <= IW'(apply_strb(32'(init_r), wdata, wstrb));
        if (sel && (wr_off == OFF_UPD))  upd_r  <= UW'(apply_strb(32'(upd_r), wdata, wstrb));
      end
    end

    assign dec_q[c]  = dec_r;
    assign ovc_q[c]  = ovc_r;
    assign toc_q[c]  = toc_r;
    assign init_q[c] = init_r;
    assign upd_q[c]  = upd_r;

    net_iso_stat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_cnt (
      .aclk   (aclk),
      .areset (areset),
      .inc    (rx_packet_dropped[c]),
      .clr    (sel && (wr_off == OFF_STAT) && wstrb[0]),
      .cnt    (cnt_q[c])
    );

`ifdef NET_ISO_IRQ_EN
    logic [1:0] mask_r;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset)                                  mask_r <= 2'b00;
      else if (sel && (wr_off == OFF_MASK) && wstrb[0]) mask_r <= wdata[1:0];
    end
    assign mask_q[c] = mask_r;
`endif
  end

  assign decouple             = dec_q;
  assign oversize_error_clear = ovc_q;
  assign timeout_error_clear  = toc_q;
  assign init_token           = init_q;
  assign upd_token            = upd_q;

  // ---------------- read path ----------------
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == 8'(c)) begin
        case (rd_off)
          OFF_CTRL: rd_word = {28'd0, decouple_status_vector[2*c +: 2], decouple_done[c], dec_q[c]};
          OFF_ERR:  rd_word = {28'd0, timeout_error_irq[c], oversize_error_irq[c], 1'b0, ovc_q[c]};
          OFF_INIT: rd_word = 32'(init_q[c]);
          OFF_UPD:  rd_word = 32'(upd_q[c]);
          OFF_STAT: rd_word = 32'(cnt_q[c]);
`ifdef NET_ISO_IRQ_EN
          OFF_MASK: rd_word = {30'd0, mask_q[c]};
`endif
          default:  rd_word = '0;
        endcase
      end
    end
  end

  // Sampled in R_ACK, so a write committing in the same cycle is not yet visible.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (rd_st == R_ACK) begin
      rdata_q <= rd_hit ? rd_word : '0;
      rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- interrupt ----------------
`ifdef NET_ISO_IRQ_EN
  logic irq_q;
  logic [NUM_CH-1:0] irq_src;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_irq
    assign irq_src[c] = (oversize_error_irq[c] & mask_q[c][0]) | (timeout_error_irq[c] & mask_q[c][1]);
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) irq_q <= 1'b0;
    else        irq_q <= |irq_src;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_net_iso_multi_reg_file.sv
// Directed bench for net_iso_multi_reg_file (NUM_CH=4, STAT_WIDTH=4); irq checks follow NET_ISO_IRQ_EN.
module tb_net_iso_multi_reg_file;
  localparam int NUM_CH = 4;
  localparam int IW     = 16;
  localparam int FW     = 8;
  localparam int SW     = 4;

  logic                    aclk, areset;
  logic [31:0]             awaddr, wdata, araddr, rdata;
  logic [3:0]              wstrb;
  logic                    awvalid, awready, wvalid, wready, bvalid, bready;
  logic                    arvalid, arready, rvalid, rready;
  logic [1:0]              bresp, rresp;
  logic [NUM_CH-1:0]       decouple, decouple_done, oversize_error_irq, oversize_error_clear;
  logic [NUM_CH-1:0]       timeout_error_irq, timeout_error_clear, rx_packet_dropped;
  logic [2*NUM_CH-1:0]     decouple_status_vector;
  logic [NUM_CH*IW-1:0]    init_token;
  logic [NUM_CH*(FW+1)-1:0] upd_token;
  logic                    irq;

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] tclr_ack, tclr_resp, tclr_after;
  logic [1:0]  resp;
  logic [31:0] rd;

  net_iso_multi_reg_file #(
    .NUM_CH(NUM_CH), .TOKEN_COUNT_INT_WIDTH(IW),
    .TOKEN_COUNT_FRAC_WIDTH(FW), .STAT_WIDTH(SW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .decouple(decouple), .decouple_done(decouple_done),
    .decouple_status_vector(decouple_status_vector),
    .oversize_error_irq(oversize_error_irq), .oversize_error_clear(oversize_error_clear),
    .timeout_error_irq(timeout_error_irq), .timeout_error_clear(timeout_error_clear),
    .rx_packet_dropped(rx_packet_dropped),
    .init_token(init_token), .upd_token(upd_token), .irq(irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [3:0] drop, output logic [1:0] r);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(posedge aclk); #1; n++; end while (!awready && n < 20);
    if (!awready) chk("wr_ack_timeout", 32'(awready), 32'd1);
    rx_packet_dropped = drop;
    tclr_ack = timeout_error_clear;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rx_packet_dropped = '0;
    tclr_resp = timeout_error_clear;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!bvalid) chk("wr_resp_timeout", 32'(bvalid), 32'd1);
    r = bresp;
    @(posedge aclk); #1;
    bready = 1'b0;
    tclr_after = timeout_error_clear;
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin @(posedge aclk); #1; n++; end while (!arready && n < 20);
    if (!arready) chk("rd_ack_timeout", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!rvalid) chk("rd_data_timeout", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    decouple_done = '0; decouple_status_vector = '0;
    oversize_error_irq = '0; timeout_error_irq = '0; rx_packet_dropped = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_decouple", 32'(decouple), 32'h0);
    chk("rst_init_token", init_token[31:0], 32'h0);
    chk("rst_upd_token", upd_token[31:0], 32'h0);
    chk("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 32'h0);
    chk("rst_resp", {28'd0, bresp, rresp}, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // decouple on channel 1
    axi_wr(32'h020, 32'h1, 4'hF, 4'h0, resp);
    chk("wr_ctrl1_bresp", 32'(resp), 32'h0);
    chk("decouple_ch1", 32'(decouple), 32'h2);
    decouple_done = 4'b0010; decouple_status_vector = 8'b0000_1100;
    axi_rd(32'h020, rd, resp);
    chk("rd_ctrl1_data", rd, 32'hF);
    chk("rd_ctrl1_rresp", 32'(resp), 32'h0);

    // timeout clear pulse on channel 2
    oversize_error_irq = 4'b0100;
    axi_wr(32'h044, 32'h2, 4'hF, 4'h0, resp);
    chk("tclr_during_ack", 32'(tclr_ack), 32'h0);
    chk("tclr_after_write", 32'(tclr_resp), 32'h4);
    chk("tclr_next_cycle", 32'(tclr_after), 32'h0);
    axi_rd(32'h044, rd, resp);
    chk("rd_err2", rd, 32'h4);
    axi_wr(32'h044, 32'h1, 4'hF, 4'h0, resp);
    chk("ovclr_ch2", 32'(oversize_error_clear), 32'h4);
    oversize_error_irq = '0;

    // byte-lane strobes on init_token
    axi_wr(32'h008, 32'h1234, 4'hF, 4'h0, resp);
    chk("init0_full", 32'(init_token[15:0]), 32'h1234);
    axi_wr(32'h008, 32'hABCD, 4'h1, 4'h0, resp);
    chk("init0_lowbyte", 32'(init_token[15:0]), 32'h12CD);
    axi_rd(32'h008, rd, resp);
    chk("rd_init0", rd, 32'h12CD);

    // upd_token width truncation and zero-extension on channel 3
    axi_wr(32'h06C, 32'hFFFF_FFFF, 4'hF, 4'h0, resp);
    chk("upd3", 32'(upd_token[27 +: 9]), 32'h1FF);
    axi_rd(32'h06C, rd, resp);
    chk("rd_upd3", rd, 32'h1FF);

    // drop counter saturation and clear
    rx_packet_dropped = 4'b0001;
    repeat (20) @(posedge aclk);
    #1;
    rx_packet_dropped = '0;
    axi_rd(32'h010, rd, resp);
    chk("cnt0_saturated", rd, 32'hF);
    axi_rd(32'h030, rd, resp);
    chk("cnt1_untouched", rd, 32'h0);
    axi_wr(32'h010, 32'h0, 4'h2, 4'h0, resp);
    axi_rd(32'h010, rd, resp);
    chk("cnt0_no_clear_wo_strb0", rd, 32'hF);
    axi_wr(32'h010, 32'h0, 4'hF, 4'b0001, resp);
    axi_rd(32'h010, rd, resp);
    chk("cnt0_clear_priority", rd, 32'h0);
    rx_packet_dropped = 4'b0001;
    @(posedge aclk); #1;
    rx_packet_dropped = '0;
    axi_rd(32'h010, rd, resp);
    chk("cnt0_one_pulse", rd, 32'h1);

    // unmapped accesses
    axi_rd(32'h0A0, rd, resp);
    chk("rd_oob_rresp", 32'(resp), 32'h2);
    chk("rd_oob_rdata", rd, 32'h0);
    axi_wr(32'h0A0, 32'hFFFF_FFFF, 4'hF, 4'h0, resp);
    chk("wr_oob_bresp", 32'(resp), 32'h2);
    axi_rd(32'h018, rd, resp);
    chk("rd_hole_rresp", 32'(resp), 32'h2);

`ifdef NET_ISO_IRQ_EN
    oversize_error_irq = 4'b0010;
    repeat (2) @(posedge aclk);
    #1;
    chk("irq_masked_off", 32'(irq), 32'h0);
    oversize_error_irq = '0;
    axi_wr(32'h034, 32'h1, 4'hF, 4'h0, resp);
    chk("wr_mask1_bresp", 32'(resp), 32'h0);
    axi_rd(32'h034, rd, resp);
    chk("rd_mask1", rd, 32'h1);
    oversize_error_irq = 4'b0010;
    chk("irq_not_yet", 32'(irq), 32'h0);
    @(posedge aclk); #1;
    chk("irq_one_cycle_later", 32'(irq), 32'h1);
    oversize_error_irq = '0; timeout_error_irq = 4'b0010;
    @(posedge aclk); #1;
    chk("irq_timeout_unmasked", 32'(irq), 32'h0);
    timeout_error_irq = '0;
`else
    oversize_error_irq = 4'hF; timeout_error_irq = 4'hF;
    repeat (2) @(posedge aclk);
    #1;
    chk("irq_tied_off", 32'(irq), 32'h0);
    oversize_error_irq = '0; timeout_error_irq = '0;
    axi_rd(32'h034, rd, resp);
    chk("rd_mask_unmapped", 32'(resp), 32'h2);
    axi_wr(32'h034, 32'h1, 4'hF, 4'h0, resp);
    chk("wr_mask_unmapped", 32'(resp), 32'h2);
`endif

    // reset asserted while the write is being accepted
    awaddr = 32'h020; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk); #1;
    chk("midwr_in_ack", 32'(awready), 32'h1);
    areset = 1'b1;
    #1;
    chk("midwr_awready_drop", 32'(awready), 32'h0);
    chk("midwr_bvalid", 32'(bvalid), 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("midwr_no_resp", 32'(bvalid), 32'h0);
    chk("midwr_decouple", 32'(decouple), 32'h0);
    chk("midwr_init", init_token[31:0], 32'h0);

    // concurrent write and read of the same register
    awaddr = 32'h028; wdata = 32'h5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h028; arvalid = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    chk("conc_both_ack", {30'd0, awready, arready}, 32'h3);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("conc_both_valid", {30'd0, bvalid, rvalid}, 32'h3);
    chk("conc_read_old", rdata, 32'h0);
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    axi_rd(32'h028, rd, resp);
    chk("conc_read_new", rd, 32'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
